// File: rtl/mem_resp_if.sv
// Request/response bus between the multicycle core and the memory responder.
// The core drives the request fields; the responder drives busy/ready/err/rdata and its FSM state.
interface mem_resp_if;
   logic        i_req;
   logic        i_we;
   logic [3:0]  i_be;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic        o_busy;
   logic        o_ready;
   logic        o_err;
   logic [31:0] o_rdata;
   logic        o_dbg_state;

   // Handshake: i_req is sampled only on a rising edge where o_busy=0, and the request
   // fields are captured on that same edge. o_ready is a one-cycle completion pulse,
   // o_err qualifies it, and o_rdata holds the last successful read.
   modport master (
      output i_req, i_we, i_be, i_addr, i_wdata,
      input  o_busy, o_ready, o_err, o_rdata, o_dbg_state
   );

   modport slave (
      input  i_req, i_we, i_be, i_addr, i_wdata,
      output o_busy, o_ready, o_err, o_rdata, o_dbg_state
   );
endinterface

// File: rtl/mem_resp.sv
// Unified instruction/data memory responder: word RAM with byte-enable writes,
// fixed-latency completion pulse, and an error response for misaligned or out-of-range addresses.
module mem_resp #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2
) (
   input logic       i_clk,
   input logic       i_reset,
   mem_resp_if.slave bus
);
   localparam int         DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);
   localparam logic       ST_IDLE = 1'b0;
   localparam logic       ST_WAIT = 1'b1;

   logic                  state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  accept;
   logic                  complete;

   logic                  we_q;
   logic [3:0]            be_q;
   logic [31:0]           addr_q;
   logic [31:0]           wdata_q;

   logic                  acc_we;
   logic [3:0]            acc_be;
   logic [31:0]           acc_addr;
   logic [31:0]           acc_wdata;
   logic                  acc_err;
   logic [DEPTH_LOG2-1:0] acc_idx;

   logic                  ready_q;
   logic                  err_q;
   logic [31:0]           rdata_q;
   logic [31:0]           mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && (LATENCY > 1)) begin
               state_d = ST_WAIT;
               cnt_d   = LAT_M1;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // With LATENCY=1 the access happens on the accepting edge itself, so nothing is ever busy.
   always_comb begin
      accept   = (state_q == ST_IDLE) && bus.i_req;
      complete = (LATENCY == 1) ? accept : ((state_q == ST_WAIT) && (cnt_q == 4'd1));
      bus.o_busy      = (state_q == ST_WAIT);
      bus.o_dbg_state = state_q;
   end

   always_ff @(posedge i_clk) begin
      if (accept) begin
         we_q    <= bus.i_we;
         be_q    <= bus.i_be;
         addr_q  <= bus.i_addr;
         wdata_q <= bus.i_wdata;
      end
   end

   assign acc_we    = (LATENCY == 1) ? bus.i_we    : we_q;
   assign acc_be    = (LATENCY == 1) ? bus.i_be    : be_q;
   assign acc_addr  = (LATENCY == 1) ? bus.i_addr  : addr_q;
   assign acc_wdata = (LATENCY == 1) ? bus.i_wdata : wdata_q;

   assign acc_idx = acc_addr[DEPTH_LOG2+1:2];
   assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:DEPTH_LOG2+2] != '0);

   // Reset on the completion edge aborts the access: no write, no pulse.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ready_q <= complete;
         err_q   <= complete && acc_err;
         if (complete && !acc_err && !acc_we) rdata_q <= mem[acc_idx];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset && complete && !acc_err && acc_we) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
         end
      end
   end

   assign bus.o_ready = ready_q;
   assign bus.o_err   = err_q;
   assign bus.o_rdata = rdata_q;
endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp: three instances (LATENCY 2, 1, 15) checked every cycle against a
// transaction-level memory model, plus directed scenarios with constant expectations.
module tb_mem_resp;
   logic i_clk   = 1'b0;
   logic i_reset = 1'b1;
   int   cyc     = 0;
   int   n_vec   = 0;
   int   n_err   = 0;

   typedef struct packed {
      logic        busy;
      logic        ready;
      logic        err;
      logic [31:0] rdata;
      logic        st;
   } out_t;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } in_t;

   mem_resp_if b2 ();
   mem_resp_if b1 ();
   mem_resp_if b15 ();

   mem_resp #(.DEPTH_LOG2(8), .LATENCY(2))  u_l2  (.i_clk(i_clk), .i_reset(i_reset), .bus(b2));
   mem_resp #(.DEPTH_LOG2(8), .LATENCY(1))  u_l1  (.i_clk(i_clk), .i_reset(i_reset), .bus(b1));
   mem_resp #(.DEPTH_LOG2(8), .LATENCY(15)) u_l15 (.i_clk(i_clk), .i_reset(i_reset), .bus(b15));

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc++;

   int lat_of [3] = '{2, 1, 15};

   // ---------------- access helpers ----------------
   function automatic out_t get_out(input int k);
      out_t o;
      case (k)
         0:       o = '{b2.o_busy,  b2.o_ready,  b2.o_err,  b2.o_rdata,  b2.o_dbg_state};
         1:       o = '{b1.o_busy,  b1.o_ready,  b1.o_err,  b1.o_rdata,  b1.o_dbg_state};
         default: o = '{b15.o_busy, b15.o_ready, b15.o_err, b15.o_rdata, b15.o_dbg_state};
      endcase
      return o;
   endfunction

   function automatic in_t get_in(input int k);
      in_t r;
      case (k)
         0:       r = '{b2.i_req,  b2.i_we,  b2.i_be,  b2.i_addr,  b2.i_wdata};
         1:       r = '{b1.i_req,  b1.i_we,  b1.i_be,  b1.i_addr,  b1.i_wdata};
         default: r = '{b15.i_req, b15.i_we, b15.i_be, b15.i_addr, b15.i_wdata};
      endcase
      return r;
   endfunction

   task automatic drive(input int k, input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
      case (k)
         0: begin
            b2.i_req = req; b2.i_we = we; b2.i_be = be; b2.i_addr = addr; b2.i_wdata = wdata;
         end
         1: begin
            b1.i_req = req; b1.i_we = we; b1.i_be = be; b1.i_addr = addr; b1.i_wdata = wdata;
         end
         default: begin
            b15.i_req = req; b15.i_we = we; b15.i_be = be; b15.i_addr = addr; b15.i_wdata = wdata;
         end
      endcase
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 8)       return 32'($urandom_range(0, 15)) * 4;
      else if (r == 8) return (32'($urandom_range(0, 15)) * 4) | 32'($urandom_range(1, 3));
      else             return $urandom | 32'h400;
   endfunction

   // One transaction from an idle or ready cycle; returns in the o_ready cycle.
   task automatic issue(input int k, input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                        output int lat_seen, output int busy_seen);
      int   n;
      out_t o;
      n = 0;
      while (get_out(k).busy && n < 40) begin
         @(posedge i_clk); #1; n++;
      end
      drive(k, 1'b1, we, be, addr, wdata);
      @(posedge i_clk); #1;
      drive(k, 1'b0, 1'($urandom), 4'($urandom), $urandom, $urandom);
      lat_seen  = 1;
      busy_seen = 0;
      o = get_out(k);
      while (!o.ready && lat_seen < 40) begin
         if (o.busy) busy_seen++;
         @(posedge i_clk); #1;
         lat_seen++;
         o = get_out(k);
      end
      rd = o.rdata;
      er = o.err;
   endtask

   // ---------------- reference model ----------------
   logic [31:0] ref_mem   [3][256];
   bit          pv        [3];
   int          p_due     [3];
   in_t         p_req     [3];
   int          next_free [3];
   logic [31:0] last_rd   [3];
   bit          mon_on = 1'b0;

   // Each request takes effect LATENCY cycles after acceptance; the responder is free
   // again in that completion cycle. Outputs are checked on the falling edge.
   always @(negedge i_clk) begin
      out_t o;
      in_t  r;
      logic exp_rdy;
      logic exp_err;
      int   widx;
      for (int k = 0; k < 3; k++) begin
         if (mon_on) begin
            o       = get_out(k);
            exp_rdy = pv[k] && (p_due[k] == cyc);
            exp_err = 1'b0;
            if (exp_rdy) begin
               exp_err = (p_req[k].addr % 4 != 0) || (p_req[k].addr >= 32'h400);
               if (!exp_err) begin
                  widx = int'(p_req[k].addr / 4);
                  if (p_req[k].we) begin
                     for (int b = 0; b < 4; b++)
                        if (p_req[k].be[b]) ref_mem[k][widx][8*b +: 8] = p_req[k].wdata[8*b +: 8];
                  end else begin
                     last_rd[k] = ref_mem[k][widx];
                  end
               end
               pv[k] = 1'b0;
            end
            check($sformatf("L%0d busy", lat_of[k]),  32'(o.busy),  32'(cyc < next_free[k]));
            check($sformatf("L%0d ready", lat_of[k]), 32'(o.ready), 32'(exp_rdy));
            check($sformatf("L%0d err", lat_of[k]),   32'(o.err),   32'(exp_err));
            check($sformatf("L%0d rdata", lat_of[k]), o.rdata,      last_rd[k]);
         end
         r = get_in(k);
         if (i_reset) begin
            pv[k]        = 1'b0;
            next_free[k] = cyc + 1;
            last_rd[k]   = '0;
         end else if (mon_on && r.req && !(cyc < next_free[k])) begin
            pv[k]        = 1'b1;
            p_due[k]     = cyc + lat_of[k];
            p_req[k]     = r;
            next_free[k] = cyc + lat_of[k];
         end
      end
      if (i_reset) mon_on = 1'b1;
   end

   // ---------------- stimulus ----------------
   logic [31:0] init_val [3][16];

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat, nb, rcount, ecount, bcount;
      out_t        o;

      for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (3) @(posedge i_clk);
      #1 i_reset = 1'b0;

      for (int k = 0; k < 3; k++) begin
         o = get_out(k);
         check($sformatf("L%0d reset busy", lat_of[k]),  32'(o.busy),  32'd0);
         check($sformatf("L%0d reset ready", lat_of[k]), 32'(o.ready), 32'd0);
         check($sformatf("L%0d reset err", lat_of[k]),   32'(o.err),   32'd0);
         check($sformatf("L%0d reset rdata", lat_of[k]), o.rdata,      32'd0);
         check($sformatf("L%0d reset state", lat_of[k]), 32'(o.st),    32'd0);
      end

      // Known contents for words 0..15 of every instance.
      for (int k = 0; k < 3; k++)
         for (int w = 0; w < 16; w++) begin
            init_val[k][w] = $urandom;
            issue(k, 1'b1, 4'hF, 32'(w * 4), init_val[k][w], rd, er, lat, nb);
            check("init write err", 32'(er), 32'd0);
         end

      // Full-word write then read, LATENCY=2.
      issue(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat, nb);
      check("wr latency", 32'(lat), 32'd2);
      check("wr busy cycles", 32'(nb), 32'd1);
      issue(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat, nb);
      check("rd latency", 32'(lat), 32'd2);
      check("rd busy cycles", 32'(nb), 32'd1);
      check("rd data", rd, 32'hDEADBEEF);
      check("rd err", 32'(er), 32'd0);

      // Byte enables.
      issue(0, 1'b1, 4'hF, 32'h20, 32'h11223344, rd, er, lat, nb);
      issue(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, rd, er, lat, nb);
      issue(0, 1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat, nb);
      check("be merge", rd, 32'h11BB33DD);

      // Error responses leave o_rdata alone.
      issue(0, 1'b0, 4'h0, 32'h22, 32'h0, rd, er, lat, nb);
      check("misaligned err", 32'(er), 32'd1);
      check("misaligned rdata", rd, 32'h11BB33DD);
      issue(0, 1'b0, 4'h0, 32'h400, 32'h0, rd, er, lat, nb);
      check("oor rd err", 32'(er), 32'd1);
      check("oor rd rdata", rd, 32'h11BB33DD);
      issue(0, 1'b1, 4'hF, 32'h400, 32'h55555555, rd, er, lat, nb);
      check("oor wr err", 32'(er), 32'd1);
      issue(0, 1'b0, 4'h0, 32'h0, 32'h0, rd, er, lat, nb);
      check("word0 after oor wr", rd, init_val[0][0]);

      // Empty byte mask completes without modifying anything.
      issue(0, 1'b1, 4'h0, 32'h10, 32'h0, rd, er, lat, nb);
      check("be0 latency", 32'(lat), 32'd2);
      issue(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat, nb);
      check("be0 keeps word", rd, 32'hDEADBEEF);

      // Held request, LATENCY=2: busy-cycle requests are misaligned and must be ignored.
      rcount = 0; ecount = 0;
      for (int i = 0; i < 6; i++) begin
         drive(0, 1'b1, 1'b0, 4'h0, (i % 2 == 0) ? 32'((i / 2) * 4) : 32'h3, 32'h0);
         @(posedge i_clk); #1;
         if (get_out(0).ready) rcount++;
         if (get_out(0).err)   ecount++;
      end
      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      check("b2b L2 readies", 32'(rcount), 32'd3);
      check("b2b L2 errs", 32'(ecount), 32'd0);
      check("b2b L2 last rdata", get_out(0).rdata, init_val[0][2]);

      // Reset during WAIT aborts the write.
      drive(0, 1'b1, 1'b1, 4'hF, 32'h30, 32'hCAFEF00D);
      @(posedge i_clk); #1;
      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      i_reset = 1'b1;
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      o = get_out(0);
      check("abort busy", 32'(o.busy), 32'd0);
      check("abort ready", 32'(o.ready), 32'd0);
      check("abort err", 32'(o.err), 32'd0);
      check("abort rdata", o.rdata, 32'd0);
      rcount = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge i_clk); #1;
         if (get_out(0).ready) rcount++;
      end
      check("abort no ready", 32'(rcount), 32'd0);
      issue(0, 1'b0, 4'h0, 32'h30, 32'h0, rd, er, lat, nb);
      check("abort kept word", rd, init_val[0][12]);

      // LATENCY=1: one completion every cycle, never busy.
      rcount = 0; bcount = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1, 1'b1, 1'b0, 4'h0, 32'((i % 3) * 4), 32'h0);
         @(posedge i_clk); #1;
         if (get_out(1).ready) rcount++;
         if (get_out(1).busy)  bcount++;
      end
      drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      check("b2b L1 readies", 32'(rcount), 32'd6);
      check("b2b L1 busy", 32'(bcount), 32'd0);
      check("b2b L1 last rdata", get_out(1).rdata, init_val[1][2]);

      // LATENCY=15.
      issue(2, 1'b0, 4'h0, 32'h4, 32'h0, rd, er, lat, nb);
      check("L15 latency", 32'(lat), 32'd15);
      check("L15 busy cycles", 32'(nb), 32'd14);
      check("L15 rdata", rd, init_val[2][1]);

      // Random traffic on all three instances, with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < 3; k++)
            drive(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                  rand_addr(), $urandom);
         i_reset = ($urandom_range(0, 199) == 0);
         @(posedge i_clk); #1;
      end
      i_reset = 1'b0;
      for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (20) @(posedge i_clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
